// File: rtl/sync_pulse_pkg.sv
// Shared definitions for the stretched-pulse clock-domain crossing.
// The transmit side imports the same default so both ends agree on latency.
package sync_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage : sync_pulse_pkg

// File: rtl/sync_chain.sv
// Generic N-stage single-bit synchronizer with asynchronous active-low reset to 0.
// Used for the request on this side and for ack on the source side.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: non-blocking assignment so each stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/sync_pulse_rx.sv
// Receive side of the stretched-pulse CDC: synchronizes the request, filters short
// pulses, acknowledges the source and queues accepted events as a valid/ready stream.
module sync_pulse_rx
  import sync_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned MIN_HIGH    = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  output logic             ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [3:0]       MIN_HIGH_L = 4'(MIN_HIGH);
  localparam logic [CNT_W-1:0] PEND_MAX   = '1;

  logic s;

  state_e           state_q,     state_d;
  logic [3:0]       width_q,     width_d;
  logic             ack_q,       ack_d;
  logic [CNT_W-1:0] pending_q,   pending_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q,   overrun_d;

  logic       accept;
  logic       pop;
  logic [3:0] width_inc;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_in (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in),
    .q       (s)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    accept    = 1'b0;
    width_inc = width_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (MIN_HIGH == 1) begin
            accept  = 1'b1;
            state_d = WAIT_LOW;
            width_d = MIN_HIGH_L;
          end else begin
            state_d = HIGH;
            width_d = 4'd1;
          end
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = IDLE;
          width_d = '0;
        end else if (width_inc >= MIN_HIGH_L) begin
          accept  = 1'b1;
          state_d = WAIT_LOW;
          width_d = MIN_HIGH_L;
        end else begin
          width_d = width_inc;
        end
      end
      WAIT_LOW: begin
        if (!s) begin
          state_d = IDLE;
          width_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        width_d = '0;
      end
    endcase

    ack_d = (state_d == WAIT_LOW);
  end

  // Pops are only honoured while valid, so the counter cannot underflow.
  always_comb begin
    pop       = out_valid_q & out_ready;
    pending_d = pending_q;
    overrun_d = overrun_q;

    unique case ({accept, pop})
      2'b10: begin
        if (pending_q == PEND_MAX) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = pending_q + CNT_W'(1);
        end
      end
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase

    // A saturated accept wins over a clear arriving on the same edge.
    if (!(accept && !pop && pending_q == PEND_MAX) && clr_overrun) begin
      overrun_d = 1'b0;
    end

    out_valid_d = (pending_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      width_q     <= '0;
      ack_q       <= 1'b0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      ack_q       <= ack_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule : sync_pulse_rx

// File: tb/tb_sync_pulse_rx.sv
// Directed bench for sync_pulse_rx: three instances (defaults, MIN_HIGH=3, CNT_W=2)
// share clock and reset; expected accept edges are queued and popped on ack.
module tb_sync_pulse_rx;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] in_v;
  logic [2:0] ready_v;
  logic [2:0] clr_v;
  wire  [2:0] ack_v;
  wire  [2:0] valid_v;
  wire  [2:0] ovr_v;
  wire  [3:0] pend0;
  wire  [3:0] pend1;
  wire  [1:0] pend2;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_pulse_rx u_dut0 (
    .clk (clk), .reset_n (rst_n), .in (in_v[0]), .ack (ack_v[0]),
    .out_valid (valid_v[0]), .out_ready (ready_v[0]), .pending (pend0),
    .overrun (ovr_v[0]), .clr_overrun (clr_v[0])
  );

  sync_pulse_rx #(.MIN_HIGH(3)) u_dut1 (
    .clk (clk), .reset_n (rst_n), .in (in_v[1]), .ack (ack_v[1]),
    .out_valid (valid_v[1]), .out_ready (ready_v[1]), .pending (pend1),
    .overrun (ovr_v[1]), .clr_overrun (clr_v[1])
  );

  sync_pulse_rx #(.CNT_W(2)) u_dut2 (
    .clk (clk), .reset_n (rst_n), .in (in_v[2]), .ack (ack_v[2]),
    .out_valid (valid_v[2]), .out_ready (ready_v[2]), .pending (pend2),
    .overrun (ovr_v[2]), .clr_overrun (clr_v[2])
  );

  function automatic int min_h(input int idx);
    return (idx == 1) ? 3 : 1;
  endfunction

  function automatic logic [3:0] pend_of(input int idx);
    case (idx)
      0:       return pend0;
      1:       return pend1;
      default: return {2'b00, pend2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int idx, input logic val, output int at);
    int n;
    n = 0;
    while (ack_v[idx] !== val && n < 40) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check(val ? "ack_rise_wait" : "ack_fall_wait", ack_v[idx], val);
  endtask

  // Full request/ack handshake; optionally forces ready/clr onto the accept edge only.
  task automatic handshake(input int idx, input bit ovr, input bit ovr_ready, input bit ovr_clr);
    int t0, acc, at, n;
    bit sv_r, sv_c;
    t0  = cyc;
    acc = t0 + SYNC + min_h(idx);
    exp_q.push_back(acc);
    sv_r = ready_v[idx];
    sv_c = clr_v[idx];
    in_v[idx] = 1'b1;
    n = 0;
    while (ack_v[idx] !== 1'b1 && n < 40) begin
      if (ovr && cyc == acc - 1) begin
        ready_v[idx] = ovr_ready;
        clr_v[idx]   = ovr_clr;
      end
      @(negedge clk);
      n++;
    end
    ready_v[idx] = sv_r;
    clr_v[idx]   = sv_c;
    check("ack_rise", ack_v[idx], 1'b1);
    check("accept_edge", cyc, exp_q.pop_front());
    in_v[idx] = 1'b0;
    t0 = cyc;
    wait_ack(idx, 1'b0, at);
    check("ack_fall_edge", at, t0 + 1 + SYNC);
  endtask

  initial begin
    int t0, rise, fall, vcnt, at;
    bit seen;

    rst_n   = 1'b0;
    in_v    = '0;
    ready_v = '0;
    clr_v   = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", ack_v[i], 1'b0);
      check("rst_valid", valid_v[i], 1'b0);
      check("rst_pending", pend_of(i), 0);
      check("rst_overrun", ovr_v[i], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Defaults: in high for three edges, consumer always ready.
    ready_v[0] = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + SYNC + 1);
    in_v[0] = 1'b1;
    rise = -1;
    fall = -1;
    vcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 2) in_v[0] = 1'b0;
      if (ack_v[0] && rise < 0) rise = cyc;
      if (!ack_v[0] && rise >= 0 && fall < 0) fall = cyc;
      if (valid_v[0]) vcnt++;
    end
    check("t1_accept_edge", rise, exp_q.pop_front());
    check("t1_ack_fall_edge", fall, t0 + 6);
    check("t1_valid_cycles", vcnt, 1);
    check("t1_pending_end", pend_of(0), 0);

    // MIN_HIGH=3: a two-cycle glitch is rejected, a held request counts once.
    in_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    in_v[1] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ack_v[1] || valid_v[1]) seen = 1'b1;
    end
    check("t2_glitch_seen", seen, 1'b0);
    check("t2_glitch_pending", pend_of(1), 0);
    handshake(1, 1'b0, 1'b0, 1'b0);
    check("t2_pending_one", pend_of(1), 1);
    ready_v[1] = 1'b1;
    @(negedge clk);
    check("t2_pending_drained", pend_of(1), 0);
    check("t2_valid_drained", valid_v[1], 1'b0);

    // Backlog of five, then drain one per edge.
    ready_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) handshake(0, 1'b0, 1'b0, 1'b0);
    check("t3_pending_5", pend_of(0), 5);
    check("t3_valid", valid_v[0], 1'b1);
    ready_v[0] = 1'b1;
    for (int e = 4; e >= 0; e--) begin
      @(negedge clk);
      check("t3_drain", pend_of(0), e);
    end
    check("t3_valid_low", valid_v[0], 1'b0);
    ready_v[0] = 1'b0;

    // Accept and pop on the same edge with two pending.
    handshake(0, 1'b0, 1'b0, 1'b0);
    handshake(0, 1'b0, 1'b0, 1'b0);
    check("t5_pending_2", pend_of(0), 2);
    handshake(0, 1'b1, 1'b1, 1'b0);
    check("t5_pending_hold", pend_of(0), 2);
    check("t5_valid_hold", valid_v[0], 1'b1);
    ready_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_drained", pend_of(0), 0);
    ready_v[0] = 1'b0;

    // CNT_W=2: saturation, sticky overrun, clear, set-beats-clear.
    for (int i = 0; i < 3; i++) handshake(2, 1'b0, 1'b0, 1'b0);
    check("t4_pending_3", pend_of(2), 3);
    check("t4_no_overrun", ovr_v[2], 1'b0);
    handshake(2, 1'b0, 1'b0, 1'b0);
    check("t4_pending_sat", pend_of(2), 3);
    check("t4_overrun_set", ovr_v[2], 1'b1);
    clr_v[2] = 1'b1;
    @(negedge clk);
    clr_v[2] = 1'b0;
    check("t4_overrun_clr", ovr_v[2], 1'b0);
    handshake(2, 1'b1, 1'b0, 1'b1);
    check("t4_set_beats_clr", ovr_v[2], 1'b1);
    check("t4_pending_sat2", pend_of(2), 3);
    check("t4_valid", valid_v[2], 1'b1);

    // Reset in WAIT_LOW with three pending; request held through release.
    handshake(0, 1'b0, 1'b0, 1'b0);
    handshake(0, 1'b0, 1'b0, 1'b0);
    in_v[0] = 1'b1;
    wait_ack(0, 1'b1, at);
    check("t6_pending_3", pend_of(0), 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", ack_v[0], 1'b0);
    check("t6_rst_pending", pend_of(0), 0);
    check("t6_rst_valid", valid_v[0], 1'b0);
    check("t6_rst_overrun2", ovr_v[2], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(cyc + SYNC + 1);
    wait_ack(0, 1'b1, at);
    check("t6_accept_edge", at, exp_q.pop_front());
    check("t6_pending_1", pend_of(0), 1);
    in_v[0] = 1'b0;
    wait_ack(0, 1'b0, at);
    check("t6_counted_once", pend_of(0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_pulse_rx
